// File: rtl/deskew_pkg.sv
// Shared constants and helpers for the deskew block.
package deskew_pkg;

  // Width of the emitted-row counter; wraps silently at 2^ROW_CNT_W.
  localparam int unsigned ROW_CNT_W = 16;

  // Delay in shift events applied to lane `lane` of an n-lane row.
  // Lane 0 arrives first, so it waits the longest.
  function automatic int unsigned lane_depth(input int unsigned n,
                                             input int unsigned lane);
    return n - 1 - lane;
  endfunction

  // Pointer width for a circular buffer of `depth` entries, never below 1 bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/deskew_lane.sv
// Single-lane delay line of DEPTH shift events built as a circular buffer.
// Reading the slot under the pointer before overwriting it yields exactly
// DEPTH events of delay. DEPTH=0 is a plain wire.
module deskew_lane
  import deskew_pkg::*;
#(
  parameter int unsigned D_W   = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           shift_en_i,
  input  logic [D_W-1:0] data_i,
  output logic [D_W-1:0] data_o
);

  generate
    if (DEPTH == 0) begin : g_wire
      // No storage in this path; the clock and control inputs are unused.
      logic lane_unused;
      assign lane_unused = ^{clk_i, rst_i, shift_en_i};
      assign data_o      = data_i;

    end else if (DEPTH == 1) begin : g_single
      // A one-entry ring has its pointer pinned at 0, so it reduces to a
      // single register loaded on every shift event.
      logic [D_W-1:0] slot_q;

      // Capture the lane input on each shift event.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          slot_q <= '0;
        end else if (shift_en_i) begin
          slot_q <= data_i;
        end
      end

      assign data_o = slot_q;

    end else begin : g_ring
      localparam int unsigned          PTR_W    = ptr_width(DEPTH);
      localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(DEPTH - 1);

      logic [D_W-1:0]   mem_q [DEPTH];
      logic [PTR_W-1:0] ptr_q;
      logic [PTR_W-1:0] ptr_d;

      // Pointer advance with wrap from the last slot back to 0.
      always_comb begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) begin
          ptr_d = '0;
        end
      end

      // Overwrite the slot just read and step the pointer on each shift event.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          ptr_q <= '0;
          for (int unsigned k = 0; k < DEPTH; k++) begin
            mem_q[k] <= '0;
          end
        end else if (shift_en_i) begin
          mem_q[ptr_q] <= data_i;
          ptr_q        <= ptr_d;
        end
      end

      // The oldest entry sits under the pointer.
      assign data_o = mem_q[ptr_q];
    end
  endgenerate

endmodule

// File: rtl/deskew.sv
// Realigns skewed systolic-array lane outputs into whole rows. Lane i is
// delayed by N-1-i shift events so all lanes of a row leave together; the
// valid bit travels through an N-1 deep line of the same kind.
module deskew
  import deskew_pkg::*;
#(
  parameter int unsigned D_W = 32,
  parameter int unsigned N   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic                 valid_in,
  input  logic [N*D_W-1:0]     data_in,
  output logic [N*D_W-1:0]     data_out,
  output logic                 valid_out,
  output logic [ROW_CNT_W-1:0] row_count
);

  logic [N*D_W-1:0]     lane_dly;
  logic                 valid_dly;

  logic [N*D_W-1:0]     data_out_q;
  logic [N*D_W-1:0]     data_out_d;
  logic                 valid_out_q;
  logic                 valid_out_d;
  logic [ROW_CNT_W-1:0] row_count_q;
  logic [ROW_CNT_W-1:0] row_count_d;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      deskew_lane #(
        .D_W   (D_W),
        .DEPTH (lane_depth(N, gi))
      ) u_lane (
        .clk_i      (clk),
        .rst_i      (rst),
        .shift_en_i (shift_en),
        .data_i     (data_in[gi*D_W +: D_W]),
        .data_o     (lane_dly[gi*D_W +: D_W])
      );
    end
  endgenerate

  deskew_lane #(
    .D_W   (1),
    .DEPTH (N - 1)
  ) u_valid (
    .clk_i      (clk),
    .rst_i      (rst),
    .shift_en_i (shift_en),
    .data_i     (valid_in),
    .data_o     (valid_dly)
  );

  // Output stage: load aligned lanes on shift events, pulse valid, count rows.
  always_comb begin
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    row_count_d = row_count_q;
    if (shift_en) begin
      data_out_d  = lane_dly;
      valid_out_d = valid_dly;
      if (valid_dly) begin
        row_count_d = row_count_q + 1'b1;
      end
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
      row_count_q <= '0;
    end else begin
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      row_count_q <= row_count_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign row_count = row_count_q;

endmodule

// File: tb/tb_deskew.sv
// Scoreboard bench for deskew with N=4, D_W=8.
module tb_deskew;

  localparam int N  = 4;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            shift_en;
  logic            valid_in;
  logic [N*DW-1:0] data_in;
  logic [N*DW-1:0] data_out;
  logic            valid_out;
  logic [15:0]     row_count;

  always #5 clk = ~clk;

  deskew #(.D_W(DW), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .shift_en  (shift_en),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .row_count (row_count)
  );

  typedef struct {
    logic [N*DW-1:0] data;
    logic [15:0]     cnt;
    int unsigned     ev;
  } exp_t;

  exp_t        sb[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [15:0] exp_cnt;
  int unsigned ev_cnt;
  logic        last_shift;
  logic [DW-1:0] rows [8][N];

  // Bench-side shift event counter and record of whether the last edge shifted.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_cnt     <= 0;
      last_shift <= 1'b0;
    end else begin
      last_shift <= shift_en;
      if (shift_en) ev_cnt <= ev_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every valid_out pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        check("row_data", data_out, e.data);
        check("row_count", row_count, e.cnt);
        check("latency_events", ev_cnt, e.ev + N);
        check("valid_after_shift", last_shift, 1);
      end
    end
  end

  task automatic step(input logic se, input logic vin, input logic [N*DW-1:0] din);
    shift_en = se;
    valid_in = vin;
    data_in  = din;
    @(posedge clk);
    #1;
  endtask

  task automatic push_row(input logic [N*DW-1:0] d);
    exp_cnt = exp_cnt + 16'd1;
    sb.push_back('{data: d, cnt: exp_cnt, ev: ev_cnt});
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    shift_en = 1'b1;
    valid_in = 1'b1;
    data_in  = '1;
    sb.delete();
    exp_cnt  = 16'd0;
    repeat (2) begin
      @(negedge clk);
      check("rst_data_out", data_out, 0);
      check("rst_valid_out", valid_out, 0);
      check("rst_row_count", row_count, 0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    shift_en = 1'b0;
    valid_in = 1'b0;
    data_in  = '0;
  endtask

  // Feed events [first, last] of a skewed stream of nrows rows from `rows`,
  // with `gap` idle cycles (valid_in and garbage data held high) after each.
  task automatic send_events(input int nrows, input int gap, input int first, input int last);
    logic [N*DW-1:0] din;
    logic [N*DW-1:0] row;
    for (int e = first; e <= last; e++) begin
      for (int i = 0; i < N; i++) begin
        int r;
        r = e - i;
        if (r >= 0 && r < nrows) din[i*DW +: DW] = rows[r][i];
        else                     din[i*DW +: DW] = 8'hEE;
      end
      if (e < nrows) begin
        for (int i = 0; i < N; i++) row[i*DW +: DW] = rows[e][i];
        push_row(row);
      end
      step(1'b1, e < nrows, din);
      repeat (gap) step(1'b0, 1'b1, {N{8'hEE}});
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4 * N && sb.size() != 0; k++) step(1'b1, 1'b0, '0);
    repeat (2) step(1'b0, 1'b0, '0);
    check("drain_empty", sb.size(), 0);
    check("final_row_count", row_count, exp_cnt);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; shift_en = 1'b0; valid_in = 1'b0; data_in = '0;
    exp_cnt = 16'd0;

    // Single row 0x10..0x13
    do_reset();
    for (int i = 0; i < N; i++) rows[0][i] = 8'(8'h10 + i);
    send_events(1, 0, 0, N - 1);
    drain();
    check("single_count", row_count, 16'd1);

    // Streaming 8 back-to-back rows
    do_reset();
    for (int r = 0; r < 8; r++)
      for (int i = 0; i < N; i++) rows[r][i] = 8'(r * 16 + i);
    send_events(8, 0, 0, 8 + N - 2);
    drain();
    check("stream_count", row_count, 16'd8);

    // Gaps: shift_en pattern 1,0,0,1,...
    do_reset();
    for (int i = 0; i < N; i++) rows[0][i] = 8'(8'h10 + i);
    send_events(1, 2, 0, N - 1);
    drain();
    check("gap_count", row_count, 16'd1);

    // Negative data 0x80..0x83
    do_reset();
    for (int i = 0; i < N; i++) rows[0][i] = 8'(8'h80 + i);
    send_events(1, 0, 0, N - 1);
    drain();

    // Reset after event 2 of a row, then a fresh row
    do_reset();
    for (int i = 0; i < N; i++) rows[0][i] = 8'(8'h30 + i);
    send_events(1, 0, 0, 2);
    do_reset();
    for (int i = 0; i < N; i++) rows[0][i] = 8'(8'hA0 + i);
    send_events(1, 0, 0, N - 1);
    drain();
    check("rst_mid_count", row_count, 16'd1);

    // Counter wrap: 65536 valid rows of zero data
    do_reset();
    for (int k = 0; k < 65536; k++) begin
      push_row('0);
      step(1'b1, 1'b1, '0);
    end
    drain();
    check("wrap_count", row_count, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/deskew.md
# deskew

Realigns skewed lane outputs of the attention-head systolic array into whole rows. Lane `i` of each row arrives `i` shift events after lane 0. The block delays lane `i` by `N-1-i` shift events, so every lane of a row leaves on the same cycle. It undoes the input skewing applied by the per-lane `sreg` delay lines and sits between the array outputs and the downstream row consumer.

## Interface
Parameters:
- `D_W`, 32, lane data width (signed)
- `N`, 4, number of lanes, N ≥ 2

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `shift_en`  in  1  advance all delay lines one step this cycle
- `valid_in`  in  1  lane 0 of a new row is present this shift event; sampled only when `shift_en`=1
- `data_in`  in  N*D_W  lane `i` at bits `[i*D_W +: D_W]`, signed
- `data_out`  out  N*D_W  aligned row, same lane packing, registered
- `valid_out`  out  1  `data_out` holds a complete aligned row, one-cycle pulse
- `row_count`  out  16  aligned rows emitted since reset, wraps at 2^16

## Operation
- Shift event: any cycle with `shift_en`=1. With `shift_en`=0, all state holds and `valid_out` is 0.
- Lane `i` delay line has depth `N-1-i` shift events:
  - Lane `N-1` has no delay; only the output register is in its path.
  - Each delayed lane is a circular buffer with one write/read pointer. The pointer wraps from `N-2-i` to 0.
  - On a shift event, read the old entry at the pointer, write `data_in` lane `i` into that slot, then advance the pointer.
- Valid path: `valid_in` enters a depth `N-1` delay line, advanced only on shift events. The delayed bit drives `valid_out` on the same event as the data it belongs to.
- On a shift event, `data_out` takes all lanes' delayed values and `valid_out` takes the delayed valid bit. When `valid_out` goes to 1, `row_count` increments on the same edge.
- Row `r` is injected with `valid_in`=1 at event `E`, its lane `i` at event `E+i`. It appears on `data_out` after event `E+N-1`.
- Back-to-back rows (`valid_in` high on consecutive events) yield `valid_out` high on consecutive shift events.
- `data_out` also updates on events with `valid_out`=0. Its contents are then don't-care.
- Arithmetic: pure data movement, no sign extension or truncation. The pointer width is `$clog2` of the depth, with a minimum of 1 bit.

## Timing
- Reset (asynchronous, immediate):
  - `data_out`=0, `valid_out`=0, `row_count`=0.
  - All delay-line storage and the valid delay line clear to 0.
  - All pointers reset to 0.
- Latency: `N-1` shift events from `valid_in` to `valid_out`, plus one register. `valid_out` is high in the cycle after the clock edge of event `E+N-1`.
- Gaps: idle cycles (`shift_en`=0) between events stretch latency in cycles, not in events. Alignment is preserved across any gap pattern.
- Reset mid-row: all in-flight partial rows are discarded and no `valid_out` is produced for them. The first event after reset release behaves as event 0.
- Wrap-around: `row_count` goes 0xFFFF → 0x0000 without a flag.
- `valid_in` while `shift_en`=0 is ignored.

## Structure
- Package `deskew_pkg`: constant `ROW_CNT_W` = 16, and a function for the lane `i` delay depth (`N-1-i`).
- Sub-module `deskew_lane` (params `D_W`, `DEPTH`):
  - Circular-buffer delay line with asynchronous reset.
  - `DEPTH`=0 degenerates to a wire.
  - Instantiated once per lane in a generate loop; the valid path reuses it with `D_W`=1.
- Top level holds the output registers and the row counter.

## Test plan
All scenarios use `N`=4 and `D_W`=8.
- Single row: lanes fed skewed, lane `i` = 0x10+i at event `i`, `valid_in`=1 at event 0 only, `shift_en` held high. Required: exactly one `valid_out` pulse, one cycle after event 3, with `data_out` lanes 0..3 = 0x10, 0x11, 0x12, 0x13, and `row_count`=1.
- Streaming: 8 back-to-back skewed rows with row `r` lane `i` = r*16+i. Required: 8 consecutive `valid_out` pulses, every row aligned, `row_count`=8.
- Gaps: same single row as the first scenario, but `shift_en` toggles 1,0,0,1,… Required: the same aligned row, `valid_out` only on cycles following a shift event.
- Negative data: lanes carry 0x80..0x83. Required: output bit-exact, no sign corruption.
- Reset mid-row: assert `rst` after event 2 of a row, then feed a fresh row. Required: no `valid_out` for the aborted row, all outputs 0 during reset, and the fresh row aligned correctly with `row_count`=1.
- Counter wrap: force 65536 valid rows. Required: `row_count` returns to 0.
